// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO plus single-outstanding sequencer in front of i2c_top.
// Define I2C_SEQ_TIMEOUT_EN to build the per-wait-state timeout timer.
module i2c_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [1:0]             rsp_status,
  output logic [$clog2(DEPTH):0] level,
  output logic                   newd,
  output logic                   op,
  output logic [6:0]             addr,
  output logic [7:0]             din,
  input  logic [7:0]             dout,
  input  logic                   busy,
  input  logic                   ack_err,
  input  logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ACK = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  // state     | meaning
  // IDLE      | waiting for a queued command; pops the head
  // ISSUE     | newd pulse to i2c_top
  // WAIT_BUSY | waiting for i2c_top to report busy (or an early done)
  // WAIT_DONE | transfer running, waiting for done
  // RESP      | response held until the host takes it
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0]   fifo_mem [DEPTH];
  logic [15:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic          err_flag;
  logic          in_txn;
  logic          rsp_load;
  logic [7:0]    rsp_data_nxt;
  logic [1:0]    rsp_status_nxt;
  logic          tmr_load;
  logic          tmr_expired;

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign level     = count;
  assign head      = fifo_mem[rd_ptr];

  assign newd      = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign in_txn    = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of 2; count separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op   <= 1'b0;
      addr <= '0;
      din  <= '0;
    end else if (pop) begin
      op   <= head[15];
      addr <= head[14:8];
      din  <= head[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (pop) begin
      err_flag <= 1'b0;
    end else if (in_txn && ack_err) begin
      err_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data   <= '0;
      rsp_status <= ST_OK;
    end else if (rsp_load) begin
      rsp_data   <= rsp_data_nxt;
      rsp_status <= rsp_status_nxt;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Down-counter loaded with TIMEOUT-1 on entry to a wait state; terminal count 0
  // lands on the TIMEOUT-th cycle spent in that state.
  logic [TW-1:0] tmr;

  assign tmr_expired = (tmr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (tmr_load) begin
      tmr <= TW'(TIMEOUT - 1);
    end else if (((state == WAIT_BUSY) || (state == WAIT_DONE)) && !tmr_expired) begin
      tmr <= tmr - 1'b1;
    end
  end
`else
  logic unused_tmr_load;

  assign unused_tmr_load = tmr_load;
  assign tmr_expired     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    tmr_load       = 1'b0;
    rsp_load       = 1'b0;
    rsp_data_nxt   = '0;
    rsp_status_nxt = ST_OK;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tmr_load  = 1'b1;
          state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        state_nxt = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        // A done here means the busy pulse was missed; complete normally.
        if (done) begin
          rsp_load       = 1'b1;
          rsp_data_nxt   = op ? dout : 8'h00;
          rsp_status_nxt = (err_flag || ack_err) ? ST_ACK : ST_OK;
          state_nxt      = RESP;
        end else if (busy) begin
          tmr_load  = 1'b1;
          state_nxt = WAIT_DONE;
        end else if (tmr_expired) begin
          rsp_load       = 1'b1;
          rsp_status_nxt = ST_TMO;
          state_nxt      = RESP;
        end
      end

      WAIT_DONE: begin
        if (done) begin
          rsp_load       = 1'b1;
          rsp_data_nxt   = op ? dout : 8'h00;
          rsp_status_nxt = (err_flag || ack_err) ? ST_ACK : ST_OK;
          state_nxt      = RESP;
        end else if (tmr_expired) begin
          rsp_load       = 1'b1;
          rsp_status_nxt = ST_TMO;
          state_nxt      = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural i2c_top stub.
// Timeout checks are compiled in only when I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic [2:0] level;
  logic       newd;
  logic       op;
  logic [6:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       ack_err;
  logic       done;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int newd_cnt  = 0;
  int done_cyc  = 0;
  int stub_mode = 0;  // 0 silent, 1 normal, 2 ack pulse, 3 done without busy, 4 busy forever

  logic [7:0] slave [128];
  logic       s_op;
  logic [6:0] s_addr;
  logic [7:0] s_din;

  i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .level(level),
    .newd(newd), .op(op), .addr(addr), .din(din),
    .dout(dout), .busy(busy), .ack_err(ack_err), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (newd) newd_cnt <= newd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, output logic [7:0] d, output logic [1:0] s);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(rsp_valid), 32'd1);
    d = rsp_data;
    s = rsp_status;
  endtask

  task automatic push_one(input logic o, input logic [6:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = o; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // i2c_top stub: small register-file slave behind the handshake.
  initial begin
    busy = 1'b0; done = 1'b0; ack_err = 1'b0; dout = 8'h00;
    for (int i = 0; i < 128; i++) slave[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (newd && stub_mode != 0) begin
        s_op = op; s_addr = addr; s_din = din;
        @(negedge clk);
        if (stub_mode == 4) begin
          busy = 1'b1;
          while (stub_mode == 4) @(negedge clk);
          busy = 1'b0;
        end else begin
          if (stub_mode != 3) begin
            busy = 1'b1;
            for (int k = 0; k < 4; k++) begin
              ack_err = (stub_mode == 2 && k == 1);
              @(negedge clk);
            end
            ack_err = 1'b0;
            busy = 1'b0;
          end
          if (!s_op) slave[s_addr] = s_din;
          dout = s_op ? slave[s_addr] : 8'hEE;
          done = 1'b1;
          done_cyc = cyc;
          @(negedge clk);
          done = 1'b0;
        end
      end
    end
  end

  logic [7:0] rd;
  logic [1:0] rs;
  logic [7:0] d0;
  logic [1:0] s0;
  int         base;
  int         acc;
  int         bad_stab;
  int         bad_lvl;
  int         bad_vld;
  int         n;

  logic       b_op   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [6:0] b_addr [4] = '{7'd2, 7'd3, 7'd2, 7'd3};
  logic [7:0] b_data [4] = '{8'h55, 8'h99, 8'h00, 8'h00};
  logic [7:0] b_exp  [4] = '{8'h00, 8'h00, 8'h55, 8'h99};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_newd", 32'(newd), 32'd0);
    chk("rst_fields", {15'd0, op, addr, din}, 32'd0);
    chk("rst_rsp", {22'd0, rsp_data, rsp_status}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/write/read/read with latency checks.
    stub_mode = 1;
    base = newd_cnt;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = b_op[i]; cmd_addr = b_addr[i]; cmd_data = b_data[i];
      @(negedge clk);
      if (i == 0) begin
        chk("push_level", 32'(level), 32'd1);
        chk("no_bypass", 32'(newd), 32'd0);
      end
      if (i == 1) begin
        chk("issue_latency", 32'(newd), 32'd1);
        chk("issue_fields", {16'd0, op, addr, din}, {16'd0, 1'b0, 7'd2, 8'h55});
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp("basic", rd, rs);
      chk("basic_data", 32'(rd), 32'(b_exp[i]));
      chk("basic_status", 32'(rs), 32'd0);
      chk("done_to_rsp", 32'(cyc - done_cyc), 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("basic_newd_count", 32'(newd_cnt - base), 32'd4);

    // Ack error pulse, then a clean transfer proving the flag is cleared.
    stub_mode = 2;
    push_one(1'b0, 7'd7, 8'h3C);
    wait_rsp("ack", rd, rs);
    chk("ack_status", 32'(rs), 32'd1);
    chk("ack_data", 32'(rd), 32'd0);
    @(negedge clk);
    stub_mode = 1;
    push_one(1'b1, 7'd7, 8'h00);
    wait_rsp("after_ack", rd, rs);
    chk("after_ack_status", 32'(rs), 32'd0);
    chk("after_ack_data", 32'(rd), 32'h3C);

    // done without a preceding busy.
    @(negedge clk);
    stub_mode = 3;
    push_one(1'b1, 7'd2, 8'h00);
    wait_rsp("nobusy", rd, rs);
    chk("nobusy_data", 32'(rd), 32'h55);
    chk("nobusy_status", 32'(rs), 32'd0);

    // Backpressure with two commands queued behind a pending response.
    @(negedge clk);
    stub_mode = 1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 7'd5; cmd_data = 8'hA1; @(negedge clk);
    cmd_op = 1'b0; cmd_addr = 7'd6; cmd_data = 8'hA2; @(negedge clk);
    cmd_op = 1'b1; cmd_addr = 7'd5; cmd_data = 8'h00; @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("bp", d0, s0);
    chk("bp_level", 32'(level), 32'd2);
    base = newd_cnt;
    bad_stab = 0; bad_lvl = 0; bad_vld = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_data !== d0 || rsp_status !== s0) bad_stab++;
      if (level !== 3'd2) bad_lvl++;
      if (rsp_valid !== 1'b1) bad_vld++;
    end
    chk("bp_stable", 32'(bad_stab), 32'd0);
    chk("bp_level_hold", 32'(bad_lvl), 32'd0);
    chk("bp_valid_hold", 32'(bad_vld), 32'd0);
    chk("bp_no_newd", 32'(newd_cnt - base), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_gap", 32'(newd), 32'd0);
    @(negedge clk);
    chk("bp_release_newd", 32'(newd), 32'd1);
    wait_rsp("bp2", rd, rs);
    chk("bp2_status", 32'(rs), 32'd0);
    wait_rsp("bp3", rd, rs);
    chk("bp3_data", 32'(rd), 32'hA1);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Timeout while waiting for busy.
    @(negedge clk);
    stub_mode = 0;
    push_one(1'b1, 7'd2, 8'h00);
    n = 0;
    while (!newd && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_newd", 32'(newd), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      if (!rsp_valid) n++;
    end while (!rsp_valid && n < 1100);
    chk("tmo_cycles", 32'(n), 32'd1000);
    chk("tmo_status", 32'(rsp_status), 32'd2);
    chk("tmo_data", 32'(rsp_data), 32'd0);
`endif

    // Fill the FIFO behind a stalled transfer, then reset mid-transaction.
    @(negedge clk);
    @(negedge clk);
    stub_mode = 4;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 7'(8 + i); cmd_data = 8'(i);
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    stub_mode = 1;
    @(negedge clk);
    chk("rstmid_level", 32'(level), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_newd", 32'(newd), 32'd0);
    rst = 1'b0;
    base = newd_cnt;
    bad_vld = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad_vld++;
    end
    chk("rstmid_no_stale_rsp", 32'(bad_vld), 32'd0);
    chk("rstmid_no_newd", 32'(newd_cnt - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
